core_weight_port_ctrl: RTL and testbench

- Initiator for the Core's standard weight port (STDW/STDR/STD_A/weight_in/weight_out).
- Write mode: assembles 288-bit stream beats into 2304-bit rows and issues one STDW per row.
- Read mode: issues STDR per row, captures weight_out and streams it back as 288-bit beats.
- Sits between the weight DMA/host stream and the Core, and holds CIM_en low while it owns the port.

---
 rtl/core_pkg.sv | 22 ++
 rtl/core_row_buffer.sv | 41 ++++
 rtl/core_weight_port_ctrl.sv | 168 ++++++++++++++++
 tb/tb_core_weight_port_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared constants and FSM encoding for the CIM core weight-port logic.
package core_pkg;

   localparam int CORE_ROWS    = 64;
   localparam int CORE_ADDR_W  = 6;
   localparam int MACRO_NUM    = 8;
   localparam int MACRO_W_BITS = 288;
   localparam int CORE_W_BITS  = MACRO_NUM * MACRO_W_BITS;
   localparam int PSUM_W       = 18;

   // Weight-port controller states: write fill/issue, read issue/wait/drain, job end.
   typedef enum logic [2:0] {
      WP_IDLE,
      WP_WR_FILL,
      WP_WR_ISSUE,
      WP_RD_ISSUE,
      WP_RD_WAIT,
      WP_RD_DRAIN,
      WP_FIN
   } wp_state_e;

endpackage

// File: rtl/core_row_buffer.sv
// One Core row held as BEATS stream-width slices. The write path fills it one
// beat at a time; the read path loads it in parallel from weight_out and then
// hands out one beat at a time.
module core_row_buffer #(
   parameter int BEAT_W = 288,
   parameter int BEATS  = 8,
   localparam int IDX_W = $clog2(BEATS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [IDX_W-1:0]        wr_idx,
   input  logic [BEAT_W-1:0]       wr_data,
   input  logic                    load_en,
   input  logic [BEAT_W*BEATS-1:0] load_data,
   input  logic [IDX_W-1:0]        rd_idx,
   output logic [BEAT_W-1:0]       rd_data,
   output logic [BEAT_W*BEATS-1:0] row_data
);

   // Slice k sits at bits [BEAT_W*k +: BEAT_W], matching the Core's weight bus.
   logic [BEATS-1:0][BEAT_W-1:0] beats_q;

   // Row storage: parallel load wins over a beat write; the two never coincide.
   always_ff @(posedge clk) begin
      // NOTE: this storage drives weight_in straight to the Core, so it is a
      // resettable flop bank rather than a RAM; a RAM would be left unreset.
      // Sequential state uses <= so every flop sees pre-edge values.
      if (rst) begin
         beats_q <= '0;
      end else if (load_en) begin
         beats_q <= load_data;
      end else if (wr_en) begin
         beats_q[wr_idx] <= wr_data;
      end
   end

   assign rd_data  = beats_q[rd_idx];
   assign row_data = beats_q;

endmodule

// File: rtl/core_weight_port_ctrl.sv
// Initiator for the Core's standard weight port. Write jobs gather BEATS stream
// beats into a row and strobe STDW; read jobs strobe STDR, capture weight_out
// after RD_LAT cycles and stream the row back beat by beat. While a job owns
// the port the CIM enable is gated off.
module core_weight_port_ctrl
   import core_pkg::*;
#(
   parameter int ADDR_W = CORE_ADDR_W,
   parameter int BEAT_W = MACRO_W_BITS,
   parameter int BEATS  = MACRO_NUM,
   parameter int RD_LAT = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_wr,
   input  logic                    start_rd,
   input  logic [ADDR_W-1:0]       row_base,
   input  logic [ADDR_W:0]         row_cnt,
   output logic                    busy,
   output logic                    done,
   input  logic                    s_valid,
   input  logic [BEAT_W-1:0]       s_data,
   output logic                    s_ready,
   output logic                    m_valid,
   output logic [BEAT_W-1:0]       m_data,
   input  logic                    m_ready,
   output logic                    cim_en_gate,
   output logic                    STDW,
   output logic                    STDR,
   output logic [ADDR_W-1:0]       STD_A,
   output logic [BEAT_W*BEATS-1:0] weight_in,
   input  logic [BEAT_W*BEATS-1:0] weight_out
);

   localparam int IDX_W = $clog2(BEATS);
   localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);
   localparam logic [LAT_W-1:0] LAST_LAT  = LAT_W'(RD_LAT - 1);

   wp_state_e           state, state_n;
   logic [ADDR_W-1:0]   row_q;
   logic [ADDR_W:0]     rows_left_q;
   logic [IDX_W-1:0]    beat_q;
   logic [LAT_W-1:0]    lat_q;
   logic [ADDR_W-1:0]   std_a_q;
   logic [BEAT_W-1:0]   buf_rd_data;

   logic beat_accept, beat_drain, last_beat, last_row, lat_done;

   assign beat_accept = s_valid & s_ready;
   assign beat_drain  = m_valid & m_ready;
   assign last_beat   = (beat_q == LAST_BEAT);
   assign last_row    = (rows_left_q == (ADDR_W+1)'(1));
   assign lat_done    = (lat_q == LAST_LAT);

   // Moore outputs decoded from the state register.
   assign busy        = (state != WP_IDLE);
   assign done        = (state == WP_FIN);
   assign cim_en_gate = ~busy;
   assign s_ready     = (state == WP_WR_FILL);
   assign m_valid     = (state == WP_RD_DRAIN);
   assign STDW        = (state == WP_WR_ISSUE);
   assign STDR        = (state == WP_RD_ISSUE);
   // The address follows the current row only while strobing, otherwise it holds.
   assign STD_A       = (STDW || STDR) ? row_q : std_a_q;
   assign m_data      = m_valid ? buf_rd_data : '0;

   core_row_buffer #(
      .BEAT_W (BEAT_W),
      .BEATS  (BEATS)
   ) u_row_buffer (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (beat_accept),
      .wr_idx    (beat_q),
      .wr_data   (s_data),
      .load_en   ((state == WP_RD_WAIT) && lat_done),
      .load_data (weight_out),
      .rd_idx    (beat_q),
      .rd_data   (buf_rd_data),
      .row_data  (weight_in)
   );

   // Next-state logic; a write start beats a simultaneous read start.
   always_comb begin
      // NOTE: assigning the default first keeps every path driven, so no latch
      // is inferred for state_n.
      state_n = state;
      case (state)
         WP_IDLE: begin
            if (start_wr) begin
               state_n = (row_cnt == '0) ? WP_FIN : WP_WR_FILL;
            end else if (start_rd) begin
               state_n = (row_cnt == '0) ? WP_FIN : WP_RD_ISSUE;
            end
         end
         WP_WR_FILL: begin
            if (beat_accept && last_beat) state_n = WP_WR_ISSUE;
         end
         WP_WR_ISSUE: begin
            state_n = last_row ? WP_FIN : WP_WR_FILL;
         end
         WP_RD_ISSUE: begin
            state_n = WP_RD_WAIT;
         end
         WP_RD_WAIT: begin
            if (lat_done) state_n = WP_RD_DRAIN;
         end
         WP_RD_DRAIN: begin
            if (beat_drain && last_beat) state_n = last_row ? WP_FIN : WP_RD_ISSUE;
         end
         WP_FIN: begin
            state_n = WP_IDLE;
         end
         default: begin
            state_n = WP_IDLE;
         end
      endcase
   end

   // State register plus job counters: row address, rows left, beat and latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= WP_IDLE;
         row_q       <= '0;
         rows_left_q <= '0;
         beat_q      <= '0;
         lat_q       <= '0;
         std_a_q     <= '0;
      end else begin
         state   <= state_n;
         std_a_q <= STD_A;
         case (state)
            WP_IDLE: begin
               beat_q <= '0;
               lat_q  <= '0;
               if (start_wr || start_rd) begin
                  row_q       <= row_base;
                  rows_left_q <= row_cnt;
               end
            end
            WP_WR_FILL: begin
               if (beat_accept) beat_q <= last_beat ? '0 : beat_q + IDX_W'(1);
            end
            WP_WR_ISSUE: begin
               // The row address is ADDR_W bits wide, so it wraps modulo the row count.
               row_q       <= row_q + ADDR_W'(1);
               rows_left_q <= rows_left_q - (ADDR_W+1)'(1);
            end
            WP_RD_WAIT: begin
               lat_q <= lat_done ? '0 : lat_q + LAT_W'(1);
            end
            WP_RD_DRAIN: begin
               if (beat_drain) begin
                  beat_q <= last_beat ? '0 : beat_q + IDX_W'(1);
                  if (last_beat) begin
                     row_q       <= row_q + ADDR_W'(1);
                     rows_left_q <= rows_left_q - (ADDR_W+1)'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_weight_port_ctrl.sv
// Self-checking bench for core_weight_port_ctrl: a table of directed jobs,
// a mid-job reset sequence and randomized jobs, all against a Core memory
// model and job-level expectations computed here.
module tb_core_weight_port_ctrl;

   localparam int ADDR_W = 6;
   localparam int BEAT_W = 288;
   localparam int BEATS  = 8;
   localparam int ROW_W  = BEAT_W * BEATS;
   localparam int RD_LAT = 2;
   localparam int BUDGET = 2000;

   logic              clk = 1'b0;
   logic              rst;
   logic              start_wr, start_rd;
   logic [ADDR_W-1:0] row_base;
   logic [ADDR_W:0]   row_cnt;
   logic              busy, done;
   logic              s_valid, s_ready;
   logic [BEAT_W-1:0] s_data;
   logic              m_valid, m_ready;
   logic [BEAT_W-1:0] m_data;
   logic              cim_en_gate, STDW, STDR;
   logic [ADDR_W-1:0] STD_A;
   logic [ROW_W-1:0]  weight_in, weight_out;

   core_weight_port_ctrl #(
      .ADDR_W (ADDR_W), .BEAT_W (BEAT_W), .BEATS (BEATS), .RD_LAT (RD_LAT)
   ) dut (
      .clk (clk), .rst (rst), .start_wr (start_wr), .start_rd (start_rd),
      .row_base (row_base), .row_cnt (row_cnt), .busy (busy), .done (done),
      .s_valid (s_valid), .s_data (s_data), .s_ready (s_ready),
      .m_valid (m_valid), .m_data (m_data), .m_ready (m_ready),
      .cim_en_gate (cim_en_gate), .STDW (STDW), .STDR (STDR), .STD_A (STD_A),
      .weight_in (weight_in), .weight_out (weight_out)
   );

   always #5 clk = ~clk;

   // Job description plus the outcome the job must produce.
   typedef struct {
      bit do_wr;
      bit do_rd;
      int base;
      int cnt;
      int s_mode;    // 0 always valid, 1 valid every other cycle, 2 random
      int r_mode;    // 0 always ready, 1 stall 3 cycles on beat 3, 2 random
      bit pat_k;     // beat k carries byte k repeated
      bit poke;      // pulse both starts while busy
      int exp_stdw;
      int exp_stdr;
      int exp_beats;
      int exp_done;  // cycle of done after the start cycle, -1 = not fixed
   } job_t;

   logic [ROW_W-1:0] mem [64];   // Core weight array model
   int n_checks = 0;
   int n_fail   = 0;
   int both_err = 0;

   task automatic check_int(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_data(input string name, input logic [BEAT_W-1:0] act, input logic [BEAT_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One comparison per row, reported on the first differing beat.
   task automatic row_check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
      int kb = 0;
      for (int k = BEATS - 1; k >= 0; k--)
         if (act[k*BEAT_W +: BEAT_W] !== exp[k*BEAT_W +: BEAT_W]) kb = k;
      check_data($sformatf("%s beat%0d", name, kb), act[kb*BEAT_W +: BEAT_W], exp[kb*BEAT_W +: BEAT_W]);
   endtask

   function automatic logic [BEAT_W-1:0] rand_beat();
      logic [BEAT_W-1:0] b;
      for (int i = 0; i < BEAT_W / 32; i++) b[i*32 +: 32] = $urandom;
      return b;
   endfunction

   function automatic logic [ROW_W-1:0] rand_row();
      logic [ROW_W-1:0] r;
      for (int k = 0; k < BEATS; k++) r[k*BEAT_W +: BEAT_W] = rand_beat();
      return r;
   endfunction

   task automatic check_reset_vals(input string tag);
      check_int({tag, " busy"},        32'(busy), 0);
      check_int({tag, " done"},        32'(done), 0);
      check_int({tag, " s_ready"},     32'(s_ready), 0);
      check_int({tag, " m_valid"},     32'(m_valid), 0);
      check_data({tag, " m_data"},     m_data, '0);
      check_int({tag, " STDW"},        32'(STDW), 0);
      check_int({tag, " STDR"},        32'(STDR), 0);
      check_int({tag, " STD_A"},       32'(STD_A), 0);
      check_int({tag, " cim_en_gate"}, 32'(cim_en_gate), 1);
      row_check({tag, " weight_in"},   weight_in, '0);
   endtask

   // Runs one job cycle by cycle, sampling at negedge and driving for the next edge.
   task automatic run_job(input job_t j, input int id);
      string nm;
      int cyc, n_stdw, n_stdr, n_beats, n_acc, acc_in_row;
      int done_cyc, last_stdw_cyc, last_beat_cyc, stall_left, due_cyc;
      int hold_err, busy_err;
      bit have_beat, prev_hold;
      logic [BEAT_W-1:0] cur_beat, held_data;
      logic [ROW_W-1:0]  exp_row, rd_row;
      logic [ADDR_W-1:0] prev_a, due_addr;
      logic [7:0]        kb;
      nm = $sformatf("job%0d", id);
      n_stdw = 0; n_stdr = 0; n_beats = 0; n_acc = 0; acc_in_row = 0;
      last_stdw_cyc = 0; last_beat_cyc = 0; stall_left = 3; due_cyc = -1;
      hold_err = 0; busy_err = 0; have_beat = 0; prev_hold = 0;
      exp_row = '0; held_data = '0; cur_beat = '0; due_addr = '0;

      @(negedge clk);
      row_base = ADDR_W'(j.base); row_cnt = 7'(j.cnt);
      start_wr = j.do_wr; start_rd = j.do_rd;
      s_valid = 0; m_ready = 0;
      prev_a = STD_A;
      @(negedge clk);
      start_wr = 0; start_rd = 0;
      row_base = ADDR_W'($urandom); row_cnt = 7'($urandom);
      cyc = 1; done_cyc = -1;

      while (done_cyc < 0 && cyc <= BUDGET) begin
         // Core model: the addressed row appears RD_LAT cycles after STDR, noise otherwise.
         weight_out = (cyc == due_cyc) ? mem[due_addr] : rand_row();
         if (STDR) begin
            check_int($sformatf("%s stdr%0d addr", nm, n_stdr), 32'(STD_A), (j.base + n_stdr) % 64);
            due_cyc = cyc + RD_LAT; due_addr = STD_A; n_stdr++;
         end
         if (STDW) begin
            check_int($sformatf("%s stdw%0d addr", nm, n_stdw), 32'(STD_A), (j.base + n_stdw) % 64);
            check_int($sformatf("%s stdw%0d beats", nm, n_stdw), acc_in_row, BEATS);
            row_check($sformatf("%s stdw%0d data", nm, n_stdw), weight_in, exp_row);
            mem[STD_A] = weight_in;
            acc_in_row = 0; last_stdw_cyc = cyc; n_stdw++;
         end
         if (STDW && STDR) both_err++;
         if (!STDW && !STDR && STD_A !== prev_a) hold_err++;
         prev_a = STD_A;
         if (busy !== 1'b1 || cim_en_gate !== 1'b0) busy_err++;

         // Read stream consumer.
         if (prev_hold) begin
            check_int({nm, " stall m_valid"}, 32'(m_valid), 1);
            check_data({nm, " stall m_data"}, m_data, held_data);
         end
         case (j.r_mode)
            0: m_ready = 1;
            1: m_ready = !(m_valid && n_beats == 3 && stall_left > 0);
            default: m_ready = 1'($urandom % 2);
         endcase
         if (j.r_mode == 1 && !m_ready) stall_left--;
         if (m_valid && m_ready) begin
            rd_row = mem[(j.base + n_beats / BEATS) % 64];
            check_data($sformatf("%s m_beat%0d", nm, n_beats), m_data,
                       rd_row[(n_beats % BEATS)*BEAT_W +: BEAT_W]);
            n_beats++; last_beat_cyc = cyc;
         end
         prev_hold = m_valid && !m_ready;
         held_data = m_data;

         // Write stream producer and extra starts while busy.
         start_wr = j.poke && cyc == 3;
         start_rd = j.poke && cyc == 3;
         case (j.s_mode)
            0: s_valid = 1;
            1: s_valid = (cyc % 2 == 0);
            default: s_valid = 1'($urandom % 2);
         endcase
         if (!have_beat) begin
            kb = 8'(n_acc % BEATS);
            cur_beat = j.pat_k ? {36{kb}} : rand_beat();
            have_beat = 1;
         end
         s_data = s_valid ? cur_beat : rand_beat();
         if (s_valid && s_ready) begin
            exp_row[acc_in_row*BEAT_W +: BEAT_W] = cur_beat;
            acc_in_row++; n_acc++; have_beat = 0;
         end

         if (done) done_cyc = cyc;
         @(negedge clk);
         cyc++;
      end
      s_valid = 0; m_ready = 0; start_wr = 0; start_rd = 0;

      check_int({nm, " done_seen"}, 32'(done_cyc >= 0), 1);
      check_int({nm, " busy_after"}, 32'(busy), 0);
      check_int({nm, " done_pulse"}, 32'(done), 0);
      check_int({nm, " cim_after"}, 32'(cim_en_gate), 1);
      check_int({nm, " stdw_cnt"}, n_stdw, j.exp_stdw);
      check_int({nm, " stdr_cnt"}, n_stdr, j.exp_stdr);
      check_int({nm, " m_beats"}, n_beats, j.exp_beats);
      check_int({nm, " s_beats"}, n_acc, j.exp_stdw * BEATS);
      check_int({nm, " busy_gate"}, busy_err, 0);
      check_int({nm, " std_a_hold"}, hold_err, 0);
      if (j.exp_done >= 0) check_int({nm, " done_cyc"}, done_cyc, j.exp_done);
      if (j.cnt > 0 && done_cyc >= 0) begin
         if (j.do_wr) check_int({nm, " done_after_stdw"}, done_cyc, last_stdw_cyc + 1);
         else         check_int({nm, " done_after_beat"}, done_cyc, last_beat_cyc + 1);
      end
   endtask

   initial begin
      job_t vecs [7];
      job_t rj;
      logic [BEAT_W-1:0] tb_beat;
      int n;

      //              wr rd base cnt  s  r  k  p stdw stdr beats done
      vecs[0] = '{1, 0,  0, 1, 0, 0, 1, 0, 1, 0,  0, 10};
      vecs[1] = '{1, 0, 62, 4, 1, 0, 0, 0, 4, 0,  0, -1};
      vecs[2] = '{0, 1,  5, 2, 0, 1, 0, 0, 0, 2, 16, 26};
      vecs[3] = '{1, 1, 10, 2, 0, 0, 0, 1, 2, 0,  0, 19};
      vecs[4] = '{0, 1, 33, 0, 0, 0, 0, 0, 0, 0,  0,  1};
      vecs[5] = '{1, 0,  7, 0, 0, 0, 0, 0, 0, 0,  0,  1};
      vecs[6] = '{1, 0, 60, 8, 0, 0, 0, 0, 8, 0,  0, 73};

      // Row-tagged Core contents: byte 35 = row, byte 34 = beat.
      for (int r = 0; r < 64; r++)
         for (int k = 0; k < BEATS; k++) begin
            tb_beat = rand_beat();
            tb_beat[BEAT_W-1 -: 16] = {8'(r), 8'(k)};
            mem[r][k*BEAT_W +: BEAT_W] = tb_beat;
         end

      rst = 1; start_wr = 0; start_rd = 0; row_base = '0; row_cnt = '0;
      s_valid = 0; s_data = '0; m_ready = 0; weight_out = '0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst = 0;

      for (int i = 0; i < 7; i++) run_job(vecs[i], i);

      // Reset after four beats of a write: partial row dropped, no Core write.
      @(negedge clk);
      row_base = 6'd20; row_cnt = 7'd2; start_wr = 1;
      @(negedge clk);
      start_wr = 0;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         s_valid = 1; s_data = rand_beat();
         if (STDW) n++;
         @(negedge clk);
      end
      s_valid = 0; rst = 1;
      @(negedge clk);
      rst = 0;
      check_reset_vals("mid_reset");
      for (int i = 0; i < 12; i++) begin
         if (STDW || STDR || busy) n++;
         @(negedge clk);
      end
      check_int("mid_reset quiet", n, 0);
      run_job(vecs[0], 100);

      // Randomized jobs; expectations follow from the job rules directly.
      for (int i = 0; i < 8; i++) begin
         rj.do_wr  = 1'($urandom % 2);
         rj.do_rd  = !rj.do_wr || ($urandom % 4 == 0);
         rj.base   = int'($urandom % 64);
         rj.cnt    = int'($urandom % 5);
         rj.s_mode = 2; rj.r_mode = 2; rj.pat_k = 0;
         rj.poke   = 1'($urandom % 2);
         rj.exp_stdw  = rj.do_wr ? rj.cnt : 0;
         rj.exp_stdr  = rj.do_wr ? 0 : rj.cnt;
         rj.exp_beats = rj.do_wr ? 0 : rj.cnt * BEATS;
         rj.exp_done  = (rj.cnt == 0) ? 1 : -1;
         run_job(rj, 200 + i);
      end

      check_int("stdw_stdr_exclusive", both_err, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
